osd_stm_event_buffer: RTL and testbench

//   Elastic buffer between a core-specific STM trace tap and the osd_stm

---
 rtl/osd_stm_event_buffer.sv | 129 ++++++++++++
 tb/tb_osd_stm_event_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/osd_stm_event_buffer.sv
// osd_stm_event_buffer
// Elastic FIFO between an STM trace tap and the osd_stm event input.
// Events arriving while the buffer is full are counted. A marker event
// {OVF_ID, drop count} is written ahead of the next accepted event, so the
// host sees every loss.
//
// Handshake: the head entry is transferred when out_valid && out_ready are
// both high on a rising clock edge. out_valid never depends on out_ready.
// out_id/out_value are held stable while out_valid && !out_ready.
// The input side has no backpressure: in_valid is a strobe that is either
// stored, dropped and counted, or ignored (reserved ids 0 and OVF_ID).
module osd_stm_event_buffer #(
  parameter int          XLEN   = 64,
  parameter int          DEPTH  = 4,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] OVF_ID = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [15:0]              in_id,
  input  logic [XLEN-1:0]          in_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_id,
  output logic [XLEN-1:0]          out_value,
  output logic                     ovf_pending,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  // Storage has no reset; its contents only matter once fill covers them.
  logic [15:0]     r_id_mem  [DEPTH];
  logic [XLEN-1:0] r_val_mem [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [FW-1:0]   r_fill;
  logic [CNT_W-1:0] r_drop_cnt;
  logic            r_ovf_pending;

  logic            w_full;
  logic            w_qual;
  logic            w_pop;
  logic            w_wr_marker;
  logic            w_wr_event;
  logic            w_wr;
  logic            w_drop;
  logic [15:0]     w_wr_id;
  logic [XLEN-1:0] w_wr_val;

  // "full" is judged on the fill at the start of the cycle, so a pop in the
  // same cycle never makes room for that cycle's write.
  assign w_full      = (r_fill == FW'(DEPTH));
  assign w_qual      = in_valid && (in_id != 16'h0000) && (in_id != OVF_ID);
  assign w_pop       = out_valid && out_ready;
  // The pending marker always wins the write slot; a concurrent event is
  // then itself a loss and starts the next drop count.
  assign w_wr_marker = r_ovf_pending && !w_full;
  assign w_wr_event  = !w_wr_marker && w_qual && !w_full;
  assign w_drop      = w_qual && (w_full || w_wr_marker);
  assign w_wr        = w_wr_marker || w_wr_event;

  // Select the entry written this cycle: marker or incoming event.
  always_comb begin
    w_wr_id  = in_id;
    w_wr_val = in_value;
    if (w_wr_marker) begin
      w_wr_id  = OVF_ID;
      w_wr_val = XLEN'(r_drop_cnt);
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_id_mem[r_wr_ptr]  <= w_wr_id;
      r_val_mem[r_wr_ptr] <= w_wr_val;
    end
  end

  // Pointers and fill level; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Drop counter (saturating) and pending-marker flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt    <= '0;
      r_ovf_pending <= 1'b0;
    end else if (w_wr_marker) begin
      r_drop_cnt    <= w_qual ? CNT_W'(1) : '0;
      r_ovf_pending <= w_qual;
    end else if (w_drop) begin
      if (r_drop_cnt != {CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      r_ovf_pending <= 1'b1;
    end
  end

  // First-word fall-through head; outputs read as zero while empty.
  always_comb begin
    out_valid = (r_fill != '0);
    out_id    = '0;
    out_value = '0;
    if (out_valid) begin
      out_id    = r_id_mem[r_rd_ptr];
      out_value = r_val_mem[r_rd_ptr];
    end
  end

  assign ovf_pending = r_ovf_pending;
  assign fill        = r_fill;

endmodule

// File: tb/tb_osd_stm_event_buffer.sv
// Directed bench for osd_stm_event_buffer (DEPTH=4, CNT_W=4, XLEN=64).
module tb_osd_stm_event_buffer;

  localparam int          XLEN   = 64;
  localparam logic [15:0] OVF    = 16'hFFFF;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0;
  logic [15:0]     in_id = '0;
  logic [XLEN-1:0] in_value = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [15:0]     out_id;
  logic [XLEN-1:0] out_value;
  logic            ovf_pending;
  logic [2:0]      fill;

  int tests = 0;
  int fails = 0;

  osd_stm_event_buffer #(
    .XLEN(XLEN), .DEPTH(4), .CNT_W(4), .OVF_ID(OVF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_id(in_id), .in_value(in_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_value(out_value),
    .ovf_pending(ovf_pending), .fill(fill)
  );

  // Driver tasks: inputs change #1 after the rising edge, checks happen there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] id, input logic [XLEN-1:0] val);
    in_valid = 1'b1;
    in_id    = id;
    in_value = val;
    step();
    in_valid = 1'b0;
    in_id    = '0;
    in_value = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check head entry, then pop it.
  task automatic expect_pop(input string tag, input logic [15:0] id, input logic [63:0] val);
    out_ready = 1'b1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_id"}, 64'(out_id), 64'(id));
    chk({tag, "_value"}, out_value, val);
    step();
  endtask

  initial begin
    // ---- Test 1: reset state and single event latency
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_id", 64'(out_id), 64'd0);
    chk("rst_value", out_value, 64'd0);
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_ovf", 64'(ovf_pending), 64'd0);
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    send(16'h0042, 64'hDEAD);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_id", 64'(out_id), 64'h42);
    chk("t1_value", out_value, 64'hDEAD);
    step();
    chk("t1_valid_gone", 64'(out_valid), 64'd0);
    chk("t1_fill", 64'(fill), 64'd0);

    // ---- Test 2: six events into four slots, marker with count 2
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(16'(i), 64'(i * 256));
    chk("t2_fill", 64'(fill), 64'd4);
    chk("t2_ovf", 64'(ovf_pending), 64'd1);
    chk("t2_head_stable", 64'(out_id), 64'd1);
    expect_pop("t2_e1", 16'd1, 64'h100);
    expect_pop("t2_e2", 16'd2, 64'h200);
    expect_pop("t2_e3", 16'd3, 64'h300);
    expect_pop("t2_e4", 16'd4, 64'h400);
    expect_pop("t2_mk", OVF, 64'd2);
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_ovf_clr", 64'(ovf_pending), 64'd0);

    // ---- Test 3: pop and write on a full FIFO -> write dropped
    out_ready = 1'b0;
    for (int i = 8; i <= 11; i++) send(16'(i), 64'(i));
    out_ready = 1'b1;
    send(16'd12, 64'd12);
    chk("t3_fill", 64'(fill), 64'd3);
    chk("t3_ovf", 64'(ovf_pending), 64'd1);
    out_ready = 1'b0;
    step();
    chk("t3_fill_mk", 64'(fill), 64'd4);
    chk("t3_ovf_clr", 64'(ovf_pending), 64'd0);
    expect_pop("t3_e9", 16'd9, 64'd9);
    expect_pop("t3_e10", 16'd10, 64'd10);
    expect_pop("t3_e11", 16'd11, 64'd11);
    expect_pop("t3_mk", OVF, 64'd1);
    chk("t3_empty", 64'(out_valid), 64'd0);

    // ---- Test 4: marker written while a concurrent event is dropped
    out_ready = 1'b0;
    for (int i = 32; i <= 35; i++) send(16'(i), 64'(i));
    send(16'h24, 64'h24);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_fill3", 64'(fill), 64'd3);
    send(16'd7, 64'd7);
    chk("t4_fill4", 64'(fill), 64'd4);
    chk("t4_ovf_kept", 64'(ovf_pending), 64'd1);
    expect_pop("t4_e21", 16'h21, 64'h21);
    expect_pop("t4_e22", 16'h22, 64'h22);
    expect_pop("t4_e23", 16'h23, 64'h23);
    expect_pop("t4_mk_a", OVF, 64'd1);
    expect_pop("t4_mk_b", OVF, 64'd1);
    chk("t4_empty", 64'(out_valid), 64'd0);
    chk("t4_ovf_clr", 64'(ovf_pending), 64'd0);

    // ---- Test 5: 20 drops saturate a 4-bit counter at 15
    out_ready = 1'b0;
    for (int i = 48; i <= 51; i++) send(16'(i), 64'(i));
    for (int i = 0; i < 20; i++) send(16'h40, 64'(i));
    chk("t5_ovf", 64'(ovf_pending), 64'd1);
    expect_pop("t5_e30", 16'h30, 64'h30);
    expect_pop("t5_e31", 16'h31, 64'h31);
    expect_pop("t5_e32", 16'h32, 64'h32);
    expect_pop("t5_e33", 16'h33, 64'h33);
    expect_pop("t5_mk", OVF, 64'd15);
    chk("t5_empty", 64'(out_valid), 64'd0);

    // ---- Test 6: reserved ids ignored; async reset clears everything
    out_ready = 1'b0;
    send(16'h0000, 64'h1);
    send(OVF, 64'h2);
    chk("t6_res_fill", 64'(fill), 64'd0);
    chk("t6_res_ovf", 64'(ovf_pending), 64'd0);
    for (int i = 80; i <= 83; i++) send(16'(i), 64'(i));
    send(16'h0000, 64'h3);
    send(OVF, 64'h4);
    chk("t6_full_res_ovf", 64'(ovf_pending), 64'd0);
    chk("t6_full_fill", 64'(fill), 64'd4);
    send(16'h54, 64'h54);
    chk("t6_drop_ovf", 64'(ovf_pending), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_fill3", 64'(fill), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_fill", 64'(fill), 64'd0);
    chk("t6_rst_ovf", 64'(ovf_pending), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t6_no_marker", 64'(out_valid), 64'd0);
    chk("t6_no_marker_fill", 64'(fill), 64'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
